fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter Data_width, default 8, meaning width of one FIFO word.
REQ-002 SHALL have parameter Burst_len, default 4, meaning the maximum number of words one grant may write (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock, the FIFO write-side clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Req  input  4  per-requester write request; bit i belongs to requester i.
REQ-006 SHALL have port Req_data  input  4*Data_width  flattened requester data; requester i owns bits [i*Data_width +: Data_width].
REQ-007 SHALL have port Full  input  1  FIFO full flag, already in the clk domain.
REQ-008 SHALL have port Gnt  output  4  one-hot or zero grant; a registered output.
REQ-009 SHALL have port Wr_en  output  1  FIFO write enable.
REQ-010 SHALL have port Wr_data  output  Data_width  FIFO write data.
REQ-011 SHALL have port Wr_count  output  16  total words written since reset; wraps from 0xFFFF to 0.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BURST.
REQ-013 In IDLE with Req != 0, SHALL select the winner by round-robin: scan from index Ptr upward modulo 4, and take the first set Req bit.
REQ-014 In that same IDLE cycle, SHALL load Gnt with the winner's one-hot value, clear the burst counter, and enter BURST at the next edge.
REQ-015 In IDLE with Req == 0, SHALL hold Gnt = 0 and remain in IDLE.
REQ-016 SHALL define a transfer cycle as one where (Gnt & Req) != 0 and Full == 0.
REQ-017 SHALL drive Wr_en = 1 combinationally only in transfer cycles.
REQ-018 SHALL drive Wr_data = the granted requester's Req_data in the same cycle as the transfer (zero latency); Wr_data is 0 when Gnt == 0.
REQ-019 On each transfer, SHALL increment the burst counter and Wr_count by 1.
REQ-020 In BURST, SHALL exit to IDLE and set Gnt = 0 at the next edge when either of these holds:
- the granted Req bit is 0;
- a transfer occurs and burst counter + 1 == Burst_len.
REQ-021 On BURST exit, SHALL set Ptr = (granted index + 1) mod 4.
REQ-022 Re-arbitration therefore costs exactly one idle cycle between bursts.
REQ-023 In BURST with Full == 1, SHALL hold Wr_en = 0 and keep the burst counter, Gnt and state unchanged; the grant persists across any Full stall length.
REQ-024 Non-granted requesters SHALL see Gnt bit = 0 and no data consumed.
REQ-025 Each requester SHALL hold Req and Req_data stable until it observes a transfer with its own Gnt bit set.
REQ-026 A requester dropping Req mid-burst SHALL forfeit the remainder of that burst, with no word written in that cycle.
REQ-027 Simultaneous requests SHALL never produce more than one Gnt bit set.

Reset
REQ-028 When rst == 1 at a clk edge, SHALL set state = IDLE, Gnt = 0, Ptr = 0, burst counter = 0 and Wr_count = 0.
REQ-029 During rst == 1, SHALL force Wr_en = 0 and Wr_data = 0 regardless of Req.
REQ-030 A reset asserted mid-burst SHALL abandon the burst with no write in the reset cycle; arbitration after reset starts from requester 0.

Verification
REQ-031 Reset, then hold Req = 4'b0000 for 5 cycles -> Gnt = 0, Wr_en = 0, Wr_count = 0.
REQ-032 Req = 4'b1111 held, data i = 8'h10+i, Full = 0, Burst_len = 4 -> Wr_data sequence is four 8'h10, one idle cycle, four 8'h11, idle, four 8'h12, idle, four 8'h13 -> Wr_count = 16.
REQ-033 Only Req[2] set, data 8'h4D, Full = 1 for 3 cycles mid-burst -> Wr_en = 0 during the stall, Gnt stays 4'b0100, and the burst completes 4 writes after Full drops.
REQ-034 Requester 1 drops Req after 2 transfers -> Gnt = 0 next cycle, Ptr = 2, Wr_count += 2.
REQ-035 Assert rst during the 3rd word of a burst -> no write that cycle, Gnt = 0 and Wr_count = 0 next cycle, first grant afterwards goes to the lowest set Req index.
REQ-036 Preload Wr_count = 0xFFFE via 0xFFFE writes (or force), then 3 transfers -> Wr_count = 0x0001.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter merging four requesters onto one FIFO write port
//   clk, rst         : rising-edge clock, synchronous active-high reset
//   Req, Req_data    : per-requester write request and flattened data (requester i owns slice i)
//   Full             : FIFO full flag, stalls the current burst without losing the grant
//   Gnt              : registered one-hot (or zero) grant
//   Wr_en, Wr_data   : FIFO write strobe and data, combinational from the granted requester
//   Wr_count         : wrapping count of words written since reset
module fifo_wr_arbiter #(
    parameter int Data_width = 8,
    parameter int Burst_len  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              Req,
    input  logic [4*Data_width-1:0] Req_data,
    input  logic                    Full,
    output logic [3:0]              Gnt,
    output logic                    Wr_en,
    output logic [Data_width-1:0]   Wr_data,
    output logic [15:0]             Wr_count
);
    typedef enum logic {IDLE, BURST} state_e;
    state_e          state_q;
    logic [3:0]      gnt_q;
    logic [3:0]      gnt_d;
    logic [1:0]      ptr_q;
    logic [1:0]      gidx;
    logic [1:0]      win;
    logic [1:0]      idx;
    logic [3:0]      cnt_q;
    logic [15:0]     wr_count_q;
    logic            held;
    logic            xfer;
    logic            last;
    // Scan offsets from high to low so the requester closest to ptr_q wins last.
    always_comb begin
        win = ptr_q;
        idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            win = Req[idx] ? idx : win;
        end
    end
    assign gnt_d = 4'b0001 << win;
    assign gidx  = {gnt_q[3] | gnt_q[2], gnt_q[3] | gnt_q[1]};
    assign held  = |(gnt_q & Req);
    assign xfer  = !rst && held && !Full;
    assign last  = (cnt_q + 4'd1) == 4'(Burst_len);
    always_comb begin
        Wr_data = '0;
        for (int i = 0; i < 4; i++)
            Wr_data = (!rst && gnt_q[i]) ? Req_data[i*Data_width +: Data_width] : Wr_data;
    end
    assign Gnt      = gnt_q;
    assign Wr_en    = xfer;
    assign Wr_count = wr_count_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_q + 16'(xfer);
            if (state_q == IDLE) begin
                if (|Req) begin
                    gnt_q   <= gnt_d;
                    cnt_q   <= '0;
                    state_q <= BURST;
                end else begin
                    gnt_q <= '0;
                end
            end else if (!held || (xfer && last)) begin
                gnt_q   <= '0;
                ptr_q   <= gidx + 2'd1;
                state_q <= IDLE;
            end else if (xfer) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with directed scenarios and randomized requester traffic
module tb_fifo_wr_arbiter;
    localparam int W  = 8;
    localparam int BL = 4;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req = '0;
    logic [4*W-1:0] req_data = '0;
    logic           full = 1'b0;
    logic [3:0]     Gnt;
    logic           Wr_en;
    logic [W-1:0]   Wr_data;
    logic [15:0]    Wr_count;
    fifo_wr_arbiter #(.Data_width(W), .Burst_len(BL)) dut (
        .clk(clk), .rst(rst), .Req(req), .Req_data(req_data), .Full(full),
        .Gnt(Gnt), .Wr_en(Wr_en), .Wr_data(Wr_data), .Wr_count(Wr_count)
    );
    always #5 clk = ~clk;
    typedef struct {logic [W-1:0] data; logic [15:0] count;} exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int owner  = -1;
    int taken  = 0;
    int mptr   = 0;
    int last_w = -1;
    logic [15:0] mcount = '0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Drive one clock cycle of inputs and advance the reference model by one cycle.
    task automatic cycle(input logic [3:0] r, input logic [4*W-1:0] d, input logic f, input logic rs);
        @(posedge clk);
        #1;
        req = r; req_data = d; full = f; rst = rs;
        #1;
        last_w = -1;
        if (rs) begin
            check("rst_wr_en", 32'(Wr_en), 0);
            check("rst_wr_data", 32'(Wr_data), 0);
            owner = -1; mptr = 0; mcount = '0; taken = 0;
        end else begin
            check("gnt", 32'(Gnt), owner < 0 ? 0 : 32'(1 << owner));
            if (owner < 0) begin
                if (r != 0) begin
                    for (int k = 3; k >= 0; k--) if (r[(mptr + k) % 4]) owner = (mptr + k) % 4;
                    taken = 0;
                end
            end else if (!r[owner]) begin
                mptr = (owner + 1) % 4;
                owner = -1;
            end else if (!f) begin
                sb.push_back('{d[owner*W +: W], mcount});
                mcount++;
                taken++;
                last_w = owner;
                if (taken == BL) begin
                    mptr = (owner + 1) % 4;
                    owner = -1;
                end
            end
        end
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (!$onehot0(Gnt)) begin
                errors++;
                $display("FAIL gnt_onehot: got %b expected at most one bit", Gnt);
            end
            if (Wr_en === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got data %0h expected no write", Wr_data);
                end else begin
                    e = sb.pop_front();
                    check("wr_data", 32'(Wr_data), 32'(e.data));
                    check("wr_count", 32'(Wr_count), 32'(e.count));
                end
            end
        end
    end
    initial begin
        logic [3:0]     r;
        logic [4*W-1:0] d;
        logic [4*W-1:0] seq = {8'h13, 8'h12, 8'h11, 8'h10};
        logic [4*W-1:0] d33 = {8'h00, 8'h4D, 8'h00, 8'h00};
        logic [4*W-1:0] mix = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        repeat (2) cycle(4'b0000, '0, 1'b0, 1'b1);
        repeat (5) cycle(4'b0000, '0, 1'b0, 1'b0);
        check("idle_gnt", 32'(Gnt), 0);
        check("idle_wr_en", 32'(Wr_en), 0);
        check("idle_count", 32'(Wr_count), 0);
        repeat (20) cycle(4'b1111, seq, 1'b0, 1'b0);
        cycle(4'b0000, seq, 1'b0, 1'b0);
        check("rr_count16", 32'(Wr_count), 16);
        repeat (3) cycle(4'b0100, d33, 1'b0, 1'b0);
        repeat (3) begin
            cycle(4'b0100, d33, 1'b1, 1'b0);
            check("stall_wr_en", 32'(Wr_en), 0);
            check("stall_gnt", 32'(Gnt), 32'h4);
        end
        repeat (2) cycle(4'b0100, d33, 1'b0, 1'b0);
        cycle(4'b0000, d33, 1'b0, 1'b0);
        check("stall_count", 32'(Wr_count), 20);
        repeat (3) cycle(4'b0010, mix, 1'b0, 1'b0);
        cycle(4'b0000, mix, 1'b0, 1'b0);
        cycle(4'b1111, mix, 1'b0, 1'b0);
        check("drop_gnt", 32'(Gnt), 0);
        check("drop_count", 32'(Wr_count), 22);
        cycle(4'b1111, mix, 1'b0, 1'b0);
        check("drop_ptr2_gnt", 32'(Gnt), 32'h4);
        cycle(4'b1111, mix, 1'b0, 1'b0);
        cycle(4'b1111, mix, 1'b0, 1'b1);
        cycle(4'b0110, mix, 1'b0, 1'b0);
        check("rst_gnt", 32'(Gnt), 0);
        check("rst_count", 32'(Wr_count), 0);
        cycle(4'b0110, mix, 1'b0, 1'b0);
        check("rst_first_gnt", 32'(Gnt), 32'h2);
        cycle(4'b0000, mix, 1'b0, 1'b0);
        cycle(4'b0000, mix, 1'b0, 1'b0);
        force dut.wr_count_q = 16'hFFFE;
        #1;
        release dut.wr_count_q;
        mcount = 16'hFFFE;
        repeat (4) cycle(4'b0001, mix, 1'b0, 1'b0);
        cycle(4'b0000, mix, 1'b0, 1'b0);
        check("wrap_count", 32'(Wr_count), 1);
        r = '0;
        d = '0;
        for (int n = 0; n < 3000; n++) begin
            cycle(r, d, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
            for (int i = 0; i < 4; i++) begin
                if (last_w == i) begin
                    if ($urandom_range(0, 2) == 0) r[i] = 1'b0;
                    else d[i*W +: W] = W'($urandom);
                end else if (!r[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        r[i] = 1'b1;
                        d[i*W +: W] = W'($urandom);
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    r[i] = 1'b0;
                end
            end
        end
        repeat (3) cycle(4'b0000, '0, 1'b0, 1'b0);
        check("sb_drain", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
